sdram_aref: RTL and testbench

Periodic auto-refresh generator for the SDRAM controller, placed directly downstream of the power-up initialisation stage. After `init_end` goes high it counts the refresh interval, raises a request to the command arbiter, and on grant drives a PRECHARGE-all / AUTO_REFRESH command sequence onto its own command and address outputs. It ends with a one-cycle `aref_end` pulse that returns the bus to the arbiter.

---
 rtl/sdram_aref.sv | 198 +++++++++++++++++++
 tb/tb_sdram_aref.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh generator: interval timer, arbiter handshake and PRECHARGE/AUTO_REFRESH sequencing.
// Optional PRECHARGE-all prefix is built only when SDRAM_AREF_PRECHARGE_EN is defined.
module sdram_aref #(
   parameter int unsigned REF_INTERVAL = 750,
   parameter int unsigned T_RP         = 2,
   parameter int unsigned T_RFC        = 4
) (
   input  logic        sclk_i,
   input  logic        reset_i,
   input  logic        init_end_i,
   input  logic        aref_en_i,
   output logic        aref_req_o,
   output logic        aref_end_o,
   output logic [3:0]  aref_cmd_o,
   output logic [11:0] aref_addr_o,
   output logic        aref_miss_o
);

   localparam logic [3:0]  CMD_NOP  = 4'b0111;
   localparam logic [3:0]  CMD_PRE  = 4'b0010;
   localparam logic [3:0]  CMD_AREF = 4'b0001;
   localparam logic [11:0] ADDR_ALL = 12'h400;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_REQ      = 3'd1;
`ifdef SDRAM_AREF_PRECHARGE_EN
   localparam logic [2:0] S_PRE      = 3'd2;
   localparam logic [2:0] S_WAIT_RP  = 3'd3;
   localparam logic [15:0] RP_LOAD   = (T_RP > 1) ? 16'(T_RP - 2) : 16'd0;
`endif
   localparam logic [2:0] S_REF      = 3'd4;
   localparam logic [2:0] S_WAIT_RFC = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam logic [15:0] CNT_LAST  = 16'(REF_INTERVAL - 1);
   localparam logic [15:0] RFC_LOAD  = (T_RFC > 1) ? 16'(T_RFC - 2) : 16'd0;

   if (REF_INTERVAL < 2 || REF_INTERVAL > 65535) begin : g_bad_interval
      $error("sdram_aref: REF_INTERVAL out of range 2..65535");
   end
   if (T_RP < 1 || T_RFC < 1) begin : g_bad_timing
      $error("sdram_aref: T_RP and T_RFC must be at least 1");
   end

   logic [15:0] cnt_q, cnt_d;
   logic        expiry_q, expiry_d;
   logic [2:0]  state_q, state_d;
   logic [15:0] tmr_q, tmr_d;
   logic        pending_q, pending_d;
   logic        miss_q, miss_d;
   logic        req_q, req_d;
   logic        end_q, end_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [11:0] addr_q;

   logic exp_now;
   logic grant;
   logic in_seq;

   // Expiry is a registered pulse in the cycle the counter reads 0 after wrapping.
   assign exp_now = expiry_q & init_end_i;
   assign grant   = (state_q == S_REQ) & init_end_i & aref_en_i;
   assign in_seq  = (state_q != S_IDLE) && (state_q != S_REQ);

   always_comb begin
      cnt_d    = '0;
      expiry_d = 1'b0;
      if (init_end_i) begin
         expiry_d = (cnt_q == CNT_LAST);
         cnt_d    = expiry_d ? 16'd0 : cnt_q + 16'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      pending_d = pending_q;
      miss_d    = miss_q;

      // A grant landing on an expiry edge counts as served, so it only queues another refresh.
      if (exp_now) begin
         if (pending_q || (state_q == S_REQ && !grant)) begin
            miss_d = 1'b1;
         end else if (in_seq || grant) begin
            pending_d = 1'b1;
         end
      end
      if (!init_end_i) begin
         pending_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (exp_now) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (!init_end_i) begin
               state_d = S_IDLE;
            end else if (aref_en_i) begin
`ifdef SDRAM_AREF_PRECHARGE_EN
               state_d = S_PRE;
`else
               state_d = S_REF;
`endif
            end
         end
`ifdef SDRAM_AREF_PRECHARGE_EN
         S_PRE: begin
            if (T_RP > 1) begin
               state_d = S_WAIT_RP;
               tmr_d   = RP_LOAD;
            end else begin
               state_d = S_REF;
            end
         end
         S_WAIT_RP: begin
            if (tmr_q == 16'd0) begin
               state_d = S_REF;
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
`endif
         S_REF: begin
            if (T_RFC > 1) begin
               state_d = S_WAIT_RFC;
               tmr_d   = RFC_LOAD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_WAIT_RFC: begin
            if (tmr_q == 16'd0) begin
               state_d = S_DONE;
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
         S_DONE: begin
            state_d   = pending_d ? S_REQ : S_IDLE;
            pending_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      req_d = (state_d == S_REQ);
      end_d = (state_d == S_DONE);
      cmd_d = CMD_NOP;
`ifdef SDRAM_AREF_PRECHARGE_EN
      if (state_d == S_PRE) begin
         cmd_d = CMD_PRE;
      end
`endif
      if (state_d == S_REF) begin
         cmd_d = CMD_AREF;
      end
   end

   always_ff @(posedge sclk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q     <= '0;
         expiry_q  <= 1'b0;
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         pending_q <= 1'b0;
         miss_q    <= 1'b0;
         req_q     <= 1'b0;
         end_q     <= 1'b0;
         cmd_q     <= CMD_NOP;
         addr_q    <= ADDR_ALL;
      end else begin
         cnt_q     <= cnt_d;
         expiry_q  <= expiry_d;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         pending_q <= pending_d;
         miss_q    <= miss_d;
         req_q     <= req_d;
         end_q     <= end_d;
         cmd_q     <= cmd_d;
         addr_q    <= ADDR_ALL;
      end
   end

   assign aref_req_o  = req_q;
   assign aref_end_o  = end_q;
   assign aref_cmd_o  = cmd_q;
   assign aref_addr_o = addr_q;
   assign aref_miss_o = miss_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_sdram_aref;

`ifdef SDRAM_AREF_PRECHARGE_EN
   localparam bit PRE_ON = 1'b1;
   localparam int AREF_C = 3;
   localparam int END_C  = 7;
`else
   localparam bit PRE_ON = 1'b0;
   localparam int AREF_C = 1;
   localparam int END_C  = 5;
`endif

   localparam int K_REQ  = 0;
   localparam int K_CMD  = 1;
   localparam int K_END  = 2;
   localparam int K_MISS = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst0, init0, en0, req0, end0, miss0;
   logic [3:0]  cmd0;
   logic [11:0] addr0;
   logic        rst8, init8, en8, req8, end8, miss8;
   logic [3:0]  cmd8;
   logic [11:0] addr8;

   sdram_aref u_dut (
      .sclk_i(clk), .reset_i(rst0), .init_end_i(init0), .aref_en_i(en0),
      .aref_req_o(req0), .aref_end_o(end0), .aref_cmd_o(cmd0),
      .aref_addr_o(addr0), .aref_miss_o(miss0)
   );

   sdram_aref #(.REF_INTERVAL(8)) u_dut8 (
      .sclk_i(clk), .reset_i(rst8), .init_end_i(init8), .aref_en_i(en8),
      .aref_req_o(req8), .aref_end_o(end8), .aref_cmd_o(cmd8),
      .aref_addr_o(addr8), .aref_miss_o(miss8)
   );

   typedef struct {
      int         unit;
      int         kind;
      int         cyc;
      logic [3:0] val;
   } ev_t;

   ev_t exp_q[$];
   int total = 0;
   int bad   = 0;

   function automatic string kname(int k);
      case (k)
         K_REQ:   return "req_rise";
         K_CMD:   return "cmd";
         K_END:   return "end_pulse";
         default: return "miss_rise";
      endcase
   endfunction

   task automatic push(int u, int k, int c, logic [3:0] v);
      ev_t e;
      e.unit = u; e.kind = k; e.cyc = c; e.val = v;
      exp_q.push_back(e);
   endtask

   // Grant sampled on the edge ending cycle g; cycle g+1 is c1 of the sequence.
   task automatic push_seq(int u, int g);
      if (PRE_ON) push(u, K_CMD, g + 1, 4'b0010);
      push(u, K_CMD, g + AREF_C, 4'b0001);
      push(u, K_END, g + END_C, 4'b0000);
   endtask

   task automatic check_ev(int u, int k, logic [3:0] v);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL ev_unexpected: unit=%0d %s cyc=%0d val=%b, required no event", u, kname(k), cyc, v);
      end else begin
         e = exp_q.pop_front();
         if (e.unit != u || e.kind != k || e.cyc != cyc || e.val != v) begin
            bad++;
            $display("FAIL ev_%s: got unit=%0d %s cyc=%0d val=%b, required unit=%0d %s cyc=%0d val=%b",
                     kname(e.kind), u, kname(k), cyc, v, e.unit, kname(e.kind), e.cyc, e.val);
         end else begin
            $display("ev ok: unit=%0d %s cyc=%0d val=%b", u, kname(k), cyc, v);
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end else begin
         $display("chk ok: %s = %h", name, act);
      end
   endtask

   logic       mr[2], me[2], mm[2], prev_req[2], prev_miss[2];
   logic [3:0] mc[2];

   always @(negedge clk) begin
      mr[0] = req0; me[0] = end0; mm[0] = miss0; mc[0] = cmd0;
      mr[1] = req8; me[1] = end8; mm[1] = miss8; mc[1] = cmd8;
      for (int u = 0; u < 2; u++) begin
         if (mr[u] && !prev_req[u]) check_ev(u, K_REQ, 4'b0000);
         if (mc[u] != 4'b0111)      check_ev(u, K_CMD, mc[u]);
         if (me[u])                 check_ev(u, K_END, 4'b0000);
         if (mm[u] && !prev_miss[u]) check_ev(u, K_MISS, 4'b0000);
         prev_req[u]  = mr[u];
         prev_miss[u] = mm[u];
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start0();
      rst0 = 1'b1; init0 = 1'b0; en0 = 1'b0;
      step(2);
      rst0 = 1'b0;
      step(2);
   endtask

   int c0;
   int r8;

   initial begin
      rst0 = 1'b1; init0 = 1'b0; en0 = 1'b0;
      rst8 = 1'b1; init8 = 1'b0; en8 = 1'b0;
      prev_req[0] = 1'b0; prev_req[1] = 1'b0;
      prev_miss[0] = 1'b0; prev_miss[1] = 1'b0;

      // Long reset with init_end low: outputs must sit at reset values.
      for (int i = 0; i < 20; i++) begin
         step(1000);
         chk("reset_cmd", {28'd0, cmd0}, 32'h7);
         chk("reset_addr", {20'd0, addr0}, 32'h400);
         chk("reset_req", {31'd0, req0}, 32'h0);
      end

      // Grant held high: two refreshes one period apart.
      start0();
      c0 = cyc;
      init0 = 1'b1; en0 = 1'b1;
      push(0, K_REQ, c0 + 751, 4'b0000);
      push_seq(0, c0 + 751);
      push(0, K_REQ, c0 + 1501, 4'b0000);
      push_seq(0, c0 + 1501);
      wait_cyc(c0 + 1520);
      chk("held_queue_empty", exp_q.size(), 32'd0);
      chk("held_miss", {31'd0, miss0}, 32'h0);

      // Starvation: second expiry while still requesting raises a sticky miss.
      start0();
      c0 = cyc;
      init0 = 1'b1;
      push(0, K_REQ, c0 + 751, 4'b0000);
      push(0, K_MISS, c0 + 1501, 4'b0000);
      wait_cyc(c0 + 1550);
      chk("starve_req", {31'd0, req0}, 32'h1);
      wait_cyc(c0 + 1600);
      en0 = 1'b1;
      push_seq(0, c0 + 1600);
      wait_cyc(c0 + 1620);
      chk("starve_miss_sticky", {31'd0, miss0}, 32'h1);
      chk("starve_req_after", {31'd0, req0}, 32'h0);
      chk("starve_queue_empty", exp_q.size(), 32'd0);

      // One-cycle grant pulse: sequence still runs to completion.
      start0();
      c0 = cyc;
      init0 = 1'b1;
      push(0, K_REQ, c0 + 751, 4'b0000);
      push_seq(0, c0 + 751);
      wait_cyc(c0 + 751);
      en0 = 1'b1;
      wait_cyc(c0 + 752);
      en0 = 1'b0;
      wait_cyc(c0 + 780);
      chk("pulse_queue_empty", exp_q.size(), 32'd0);
      chk("pulse_req", {31'd0, req0}, 32'h0);

      // Grant coincident with expiry on the short-interval instance.
      rst0 = 1'b1;
      rst8 = 1'b1; init8 = 1'b0; en8 = 1'b0;
      step(2);
      rst8 = 1'b0;
      step(2);
      c0 = cyc;
      init8 = 1'b1;
      r8 = c0 + 16 + END_C + 1;
      push(1, K_REQ, c0 + 9, 4'b0000);
      push_seq(1, c0 + 16);
      push(1, K_REQ, r8, 4'b0000);
      wait_cyc(c0 + 16);
      en8 = 1'b1;
      wait_cyc(c0 + 17);
      en8 = 1'b0;
      wait_cyc(r8);
      chk("coinc_req_reassert", {31'd0, req8}, 32'h1);
      init8 = 1'b0;
      wait_cyc(r8 + 12);
      chk("coinc_miss", {31'd0, miss8}, 32'h0);
      chk("coinc_req_dropped", {31'd0, req8}, 32'h0);
      chk("coinc_queue_empty", exp_q.size(), 32'd0);
      rst8 = 1'b1;

      // Reset in c1 of a sequence: command returns to NOP at once, no end pulse.
      start0();
      c0 = cyc;
      init0 = 1'b1; en0 = 1'b1;
      push(0, K_REQ, c0 + 751, 4'b0000);
      wait_cyc(c0 + 752);
      rst0 = 1'b1;
      #1;
      chk("midreset_cmd", {28'd0, cmd0}, 32'h7);
      chk("midreset_end", {31'd0, end0}, 32'h0);
      chk("midreset_req", {31'd0, req0}, 32'h0);
      chk("midreset_addr", {20'd0, addr0}, 32'h400);
      wait_cyc(c0 + 780);
      chk("midreset_queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
